// File: rtl/hist_sequencer_if.sv
// hist_sequencer_if: sample sources A/B plus histogram core port bundle.
// master = sequencer side, slave = producers and core side.
interface hist_sequencer_if;
  logic        a_valid;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [15:0] b_data;
  logic        b_ready;
  logic [15:0] hist_data;
  logic        hist_we;
  logic        hist_ready;
  logic        hist_rd_start;
  logic        hist_valid;
  logic        hist_last;

  modport master (
    input  a_valid, a_data,
    input  b_valid, b_data,
    input  hist_ready, hist_valid, hist_last,
    output a_ready, b_ready,
    output hist_data, hist_we, hist_rd_start
  );

  modport slave (
    output a_valid, a_data,
    output b_valid, b_data,
    output hist_ready, hist_valid, hist_last,
    input  a_ready, b_ready,
    input  hist_data, hist_we, hist_rd_start
  );
endinterface

// File: rtl/hist_sequencer.sv
// hist_sequencer: arbitrates sources A/B onto the histogram core write
// port, closes frames by count or flush, then runs and checks readout.
// Ports: clk, rst_n, start, flush, bus (hist_sequencer_if.master),
// busy, frame_done, sample_cnt, rd_err.
// HIST_SEQ_RR_EN: round-robin grant; otherwise A has fixed priority.
module hist_sequencer #(
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 16,
  parameter int NUM_BINS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  hist_sequencer_if.master bus,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             rd_err
);

  typedef enum logic [2:0] {
    IDLE, ACCUM, DRAIN, READOUT, DONE
  } state_t;

  localparam int BW = $clog2(NUM_BINS + 2);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(FRAME_LEN);
  localparam logic [BW-1:0] LAST_IDX =
    BW'(NUM_BINS - 1);
  localparam logic [BW-1:0] BEAT_MAX =
    BW'(NUM_BINS + 1);

  state_t        state, state_nxt;
  logic          grant_a, grant_b;
  logic          acc_a, acc_b, acc;
  logic          frame_full, rd_go;
  logic [BW-1:0] beat_cnt;
`ifdef HIST_SEQ_RR_EN
  logic          prio_b;
`endif

  always_comb begin
`ifdef HIST_SEQ_RR_EN
    grant_a = bus.a_valid &
              (~bus.b_valid | ~prio_b);
`else
    grant_a = bus.a_valid;
`endif
    grant_b = bus.b_valid & ~grant_a;
  end

  assign bus.a_ready = (state == ACCUM) &
                       grant_a & bus.hist_ready;
  assign bus.b_ready = (state == ACCUM) &
                       grant_b & bus.hist_ready;

  assign acc_a = bus.a_valid & bus.a_ready;
  assign acc_b = bus.b_valid & bus.b_ready;
  assign acc   = acc_a | acc_b;

  assign frame_full = acc &
    (sample_cnt == FULL - CNT_W'(1));

  // readout may start only once the last write has left hist_we
  assign rd_go = (state == DRAIN) &
                 ~bus.hist_we & bus.hist_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (frame_full | flush)
                 state_nxt = DRAIN;
      DRAIN:   if (rd_go) state_nxt = READOUT;
      READOUT: if (bus.hist_valid & bus.hist_last)
                 state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.hist_data     <= '0;
      bus.hist_we       <= 1'b0;
      bus.hist_rd_start <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      sample_cnt        <= '0;
      rd_err            <= 1'b0;
      beat_cnt          <= '0;
    end else begin
      bus.hist_we       <= acc;
      bus.hist_rd_start <= rd_go;
      busy              <= state_nxt != IDLE;
      frame_done        <= (state == READOUT) &
                           bus.hist_valid &
                           bus.hist_last;
      if (acc)
        bus.hist_data <= acc_a ? bus.a_data
                               : bus.b_data;
      if (state == IDLE && start) begin
        sample_cnt <= '0;
        rd_err     <= 1'b0;
      end else if (acc && sample_cnt != FULL) begin
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (state == DRAIN) begin
        beat_cnt <= '0;
      end else if (state == READOUT &&
                   bus.hist_valid) begin
        if (bus.hist_last) begin
          if (beat_cnt != LAST_IDX)
            rd_err <= 1'b1;
        end else if (beat_cnt != BEAT_MAX) begin
          // saturate: any overrun stays a mismatch
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

`ifdef HIST_SEQ_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     prio_b <= 1'b0;
    else if (acc_a) prio_b <= 1'b1;
    else if (acc_b) prio_b <= 1'b0;
  end
`endif

endmodule

// File: doc/hist_sequencer.md
# hist_sequencer

Front-end controller for the histogramming core. Arbitrates two 16-bit sample sources onto the core's single write port, bounds each accumulation frame by sample count or explicit flush, then triggers and supervises the core's bin readout before signalling frame completion. Sits between the sample producers and the histogramming core in the top-level wrapper.

## Interface
- FRAME_LEN, 256: samples accepted per frame before automatic readout (1..2^CNT_W-1)
- CNT_W, 16: width of sample counter
- NUM_BINS, 16: expected readout beats per frame
- clk  in  1  clock, all state rises on posedge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a frame (honoured only in IDLE)
- flush  in  1  end current frame early (honoured only in ACCUM)
- a_valid / a_data  in  1 / 16  source A sample handshake
- a_ready  out  1  source A accepted when a_valid & a_ready
- b_valid / b_data  in  1 / 16  source B sample handshake
- b_ready  out  1  source B accept
- hist_data  out  16  sample to core data_in
- hist_we  out  1  core write_en, one-cycle pulse per sample
- hist_ready  in  1  core can take a write / start readout
- hist_rd_start  out  1  one-cycle pulse, core begins bin readout
- hist_valid  in  1  core readout beat valid
- hist_last  in  1  core final readout beat (qualified by hist_valid)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame
- sample_cnt  out  CNT_W  samples accepted in current frame
- rd_err  out  1  sticky: readout beat count ≠ NUM_BINS; cleared by start

## Operation
- States: IDLE, ACCUM, DRAIN, READOUT, DONE.
- IDLE: a_ready=b_ready=0. start → ACCUM, sample_cnt←0, rd_err←0.
- ACCUM: grant computed combinationally from a_valid/b_valid; x_ready = grant_x & hist_ready. At most one accept per cycle.
- Accepted sample registered to hist_data, hist_we=1 next cycle; sample_cnt increments same edge.
- Accept making sample_cnt == FRAME_LEN → DRAIN; no further accepts that frame.
- flush in ACCUM → DRAIN next edge; a sample accepted in the flush cycle is still written and counted.
- DRAIN: readies low; once no write pending and hist_ready=1, pulse hist_rd_start one cycle → READOUT.
- READOUT: count hist_valid beats; on hist_valid & hist_last → DONE; if beat count (incl. last) ≠ NUM_BINS set rd_err.
- DONE: frame_done=1 one cycle → IDLE; sample_cnt holds until next start.
- start outside IDLE and flush outside ACCUM ignored; simultaneous start+flush in IDLE: start wins.
- sample_cnt saturates at FRAME_LEN; never wraps.

## Timing
- Reset values: a_ready, b_ready, hist_we, hist_rd_start, busy, frame_done, rd_err = 0; hist_data, sample_cnt = 0; state IDLE; RR pointer favours A.
- Accept-to-write latency 1 cycle; sustained throughput 1 sample/cycle while hist_ready=1.
- Last write at cycle N → hist_rd_start no earlier than N+1.
- hist_valid & hist_last at cycle M → frame_done at M+1, busy low at M+2.
- rst_n assertion mid-frame: all outputs to reset values immediately; in-flight sample dropped; no frame_done.
- ready outputs combinational from valid inputs and hist_ready; all other outputs registered.

## Configuration
- HIST_SEQ_RR_EN defined: round-robin grant; after an A accept B has priority next contention, and vice versa.
- Undefined: fixed priority, A always wins contention; B served only when a_valid=0.

## Test plan
- Reset, start, A only streams 256 samples 0x0000..0x00FF with hist_ready=1 -> 256 hist_we pulses in order, DRAIN, hist_rd_start once, 16 beats with last -> frame_done, rd_err=0, sample_cnt=256.
- A and B valid continuously, FRAME_LEN=8 -> with HIST_SEQ_RR_EN writes alternate A,B,A,B…; without it 8 A writes, b_ready never high.
- flush asserted with same-cycle accept after 5 samples -> 6 writes, sample_cnt=6, readout follows.
- hist_ready toggled low every other cycle during ACCUM -> no accept and no hist_we while low; data order preserved.
- Core returns hist_last on beat 12 -> rd_err=1 sticky through IDLE, cleared by next start.
- rst_n pulsed low during READOUT -> outputs zero asynchronously, no frame_done, next start runs a clean frame.
